// File: rtl/player_motion_if.sv
// Controller input and player-state output bundle for player_motion.
// The master side drives the frame tick and controller byte; the slave side is the motion core.
interface player_motion_if;
    logic       frame_tick;
    logic [7:0] buttons_n;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic [1:0] state;
    logic       facing_left;
    logic       crouch;
    logic       paused;
    logic       jump_pulse;
    logic       land_pulse;

    modport master (
        output frame_tick, buttons_n,
        input  pos_x, pos_y, state, facing_left, crouch, paused, jump_pulse, land_pulse
    );

    modport slave (
        input  frame_tick, buttons_n,
        output pos_x, pos_y, state, facing_left, crouch, paused, jump_pulse, land_pulse
    );
endinterface

// File: rtl/player_motion.sv
// Platformer player motion: walking, variable-height jumping with gravity, crouch and pause,
// all advanced once per video frame on frame_tick.
module player_motion #(
    parameter int START_X    = 100,
    parameter int X_MAX      = 608,
    parameter int FLOOR_Y    = 400,
    parameter int WALK_SPEED = 2,
    parameter int JUMP_VEL   = 12,
    parameter int GRAVITY    = 1,
    parameter int MAX_FALL   = 8
) (
    input logic            clk,
    input logic            rst_n,
    player_motion_if.slave bus
);

    typedef enum logic [1:0] {
        GROUND = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        UNUSED = 2'd3
    } state_t;

    localparam logic [10:0] X_MAX_W   = 11'(X_MAX);
    localparam logic [10:0] WALK_W    = 11'(WALK_SPEED);
    localparam logic [9:0]  START_W   = 10'(START_X);
    localparam logic [9:0]  FLOOR_W   = 10'(FLOOR_Y);
    localparam logic [10:0] FLOOR_W11 = 11'(FLOOR_Y);
    localparam logic [5:0]  JUMP_W    = 6'(JUMP_VEL);
    localparam logic [5:0]  GRAV_W    = 6'(GRAVITY);
    localparam logic [6:0]  GRAV_W7   = 7'(GRAVITY);
    localparam logic [6:0]  MAX_FALL7 = 7'(MAX_FALL);

    // Registered state and its next-frame values.
    logic [9:0] pos_x_q, pos_x_d;
    logic [9:0] pos_y_q, pos_y_d;
    logic [5:0] vy_q, vy_d;
    state_t     state_q, state_d;
    logic       facing_q, facing_d;
    logic       crouch_q, crouch_d;
    logic       paused_q, paused_d;
    logic       a_prev_q, start_prev_q;
    logic       jump_q, jump_d;
    logic       land_q, land_d;

    logic a_now, start_now, down_now, left_now, right_now;
    logic a_edge, start_edge, crouch_now;
    logic [10:0] right_sum, left_diff, rise_diff, fall_sum;
    logic [6:0]  vy_inc, vy_fall;

    // Select, B and Up are not used by the motion model.
    logic unused_buttons;
    assign unused_buttons = &{1'b0, bus.buttons_n[6:5], bus.buttons_n[3]};

    assign a_now      = ~bus.buttons_n[7];
    assign start_now  = ~bus.buttons_n[4];
    assign down_now   = ~bus.buttons_n[2];
    assign left_now   = ~bus.buttons_n[1];
    assign right_now  = ~bus.buttons_n[0];
    assign a_edge     = a_now & ~a_prev_q;
    assign start_edge = start_now & ~start_prev_q;
    assign crouch_now = (state_q == GROUND) & down_now;

    // Wide intermediates so saturation compares never see a wrapped value.
    assign right_sum = {1'b0, pos_x_q} + WALK_W;
    assign left_diff = {1'b0, pos_x_q} - WALK_W;
    assign rise_diff = {1'b0, pos_y_q} - {5'b0, vy_q};
    assign vy_inc    = {1'b0, vy_q} + GRAV_W7;
    assign vy_fall   = (vy_inc > MAX_FALL7) ? MAX_FALL7 : vy_inc;
    assign fall_sum  = {1'b0, pos_y_q} + {4'b0, vy_fall};

    always_comb begin
        // NOTE: every next-value signal gets a default here so no path infers a latch.
        pos_x_d  = pos_x_q;
        pos_y_d  = pos_y_q;
        vy_d     = vy_q;
        state_d  = state_q;
        facing_d = facing_q;
        crouch_d = crouch_q;
        paused_d = paused_q;
        jump_d   = 1'b0;
        land_d   = 1'b0;

        // A Start edge spends its frame toggling pause; nothing else moves on that frame.
        if (start_edge) begin
            paused_d = ~paused_q;
        end else if (!paused_q) begin
            crouch_d = crouch_now;

            if (!crouch_now) begin
                if (right_now && !left_now) begin
                    pos_x_d  = (right_sum > X_MAX_W) ? X_MAX_W[9:0] : right_sum[9:0];
                    facing_d = 1'b0;
                end else if (left_now && !right_now) begin
                    pos_x_d  = ({1'b0, pos_x_q} < WALK_W) ? 10'd0 : left_diff[9:0];
                    facing_d = 1'b1;
                end
            end

            unique case (state_q)
                GROUND: begin
                    if (a_edge && !crouch_now) begin
                        state_d = RISE;
                        vy_d    = JUMP_W;
                        jump_d  = 1'b1;
                    end
                end
                RISE: begin
                    if (!a_now) begin
                        vy_d    = 6'd0;
                        state_d = FALL;
                    end else if ({1'b0, pos_y_q} < {5'b0, vy_q}) begin
                        pos_y_d = 10'd0;
                        vy_d    = 6'd0;
                        state_d = FALL;
                    end else begin
                        pos_y_d = rise_diff[9:0];
                        if (vy_q <= GRAV_W) begin
                            vy_d    = 6'd0;
                            state_d = FALL;
                        end else begin
                            vy_d = vy_q - GRAV_W;
                        end
                    end
                end
                FALL: begin
                    if (fall_sum >= FLOOR_W11) begin
                        pos_y_d = FLOOR_W;
                        vy_d    = 6'd0;
                        state_d = GROUND;
                        land_d  = 1'b1;
                    end else begin
                        pos_y_d = fall_sum[9:0];
                        vy_d    = vy_fall[5:0];
                    end
                end
                UNUSED: begin
                    pos_y_d = FLOOR_W;
                    vy_d    = 6'd0;
                    state_d = GROUND;
                end
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, with an asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_q      <= START_W;
            pos_y_q      <= FLOOR_W;
            vy_q         <= 6'd0;
            state_q      <= GROUND;
            facing_q     <= 1'b0;
            crouch_q     <= 1'b0;
            paused_q     <= 1'b0;
            a_prev_q     <= 1'b0;
            start_prev_q <= 1'b0;
            jump_q       <= 1'b0;
            land_q       <= 1'b0;
        end else begin
            // Pulses last exactly the one clk after the frame that raised them.
            jump_q <= 1'b0;
            land_q <= 1'b0;
            if (bus.frame_tick) begin
                pos_x_q      <= pos_x_d;
                pos_y_q      <= pos_y_d;
                vy_q         <= vy_d;
                state_q      <= state_d;
                facing_q     <= facing_d;
                crouch_q     <= crouch_d;
                paused_q     <= paused_d;
                a_prev_q     <= a_now;
                start_prev_q <= start_now;
                jump_q       <= jump_d;
                land_q       <= land_d;
            end
        end
    end

    assign bus.pos_x       = pos_x_q;
    assign bus.pos_y       = pos_y_q;
    assign bus.state       = state_q;
    assign bus.facing_left = facing_q;
    assign bus.crouch      = crouch_q;
    assign bus.paused      = paused_q;
    assign bus.jump_pulse  = jump_q;
    assign bus.land_pulse  = land_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed bench for player_motion: walking and saturation, full and short jumps, pause,
// crouch, and asynchronous reset mid-jump, each against hand-computed values.
module tb_player_motion;

    localparam logic [7:0] B_NONE  = 8'h00;
    localparam logic [7:0] B_A     = 8'h80;
    localparam logic [7:0] B_START = 8'h10;
    localparam logic [7:0] B_DOWN  = 8'h04;
    localparam logic [7:0] B_LEFT  = 8'h02;
    localparam logic [7:0] B_RIGHT = 8'h01;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   land_cnt;
    int   jump_cnt;

    player_motion_if bus ();

    player_motion dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_btn(input logic [7:0] pressed);
        bus.buttons_n = ~pressed;
    endtask

    // One frame: tick high for one posedge; returns at the following negedge.
    task automatic tick();
        @(negedge clk);
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".pos_x"},  32'(bus.pos_x), 100);
        check({tag, ".pos_y"},  32'(bus.pos_y), 400);
        check({tag, ".state"},  32'(bus.state), 0);
        check({tag, ".facing"}, 32'(bus.facing_left), 0);
        check({tag, ".crouch"}, 32'(bus.crouch), 0);
        check({tag, ".paused"}, 32'(bus.paused), 0);
        check({tag, ".jump"},   32'(bus.jump_pulse), 0);
        check({tag, ".land"},   32'(bus.land_pulse), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.frame_tick = 1'b0;
        set_btn(B_NONE);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_values("reset");

        // Walking and horizontal saturation.
        set_btn(B_RIGHT);
        ticks(10);
        check("right10.pos_x", 32'(bus.pos_x), 120);
        check("right10.facing", 32'(bus.facing_left), 0);
        set_btn(B_LEFT);
        ticks(70);
        check("left70.pos_x", 32'(bus.pos_x), 0);
        check("left70.facing", 32'(bus.facing_left), 1);
        set_btn(B_LEFT | B_RIGHT);
        tick();
        check("both.pos_x", 32'(bus.pos_x), 0);
        check("both.facing", 32'(bus.facing_left), 1);
        set_btn(B_RIGHT);
        ticks(310);
        check("right_sat.pos_x", 32'(bus.pos_x), 608);
        check("right_sat.facing", 32'(bus.facing_left), 0);

        // Full jump with A held throughout.
        set_btn(B_A);
        tick();
        check("jump0.pulse", 32'(bus.jump_pulse), 1);
        check("jump0.state", 32'(bus.state), 1);
        check("jump0.pos_y", 32'(bus.pos_y), 400);
        @(negedge clk);
        check("jump0.pulse_clear", 32'(bus.jump_pulse), 0);
        land_cnt = 0;
        for (int i = 1; i <= 26; i++) begin
            tick();
            if (bus.land_pulse) land_cnt++;
            if (i == 1) check("jump1.pos_y", 32'(bus.pos_y), 388);
            if (i == 12) begin
                check("jump12.pos_y", 32'(bus.pos_y), 322);
                check("jump12.state", 32'(bus.state), 2);
            end
        end
        check("jump26.pos_y", 32'(bus.pos_y), 400);
        check("jump26.state", 32'(bus.state), 0);
        check("jump26.land", 32'(bus.land_pulse), 1);
        check("jump.land_count", 32'(land_cnt), 1);
        tick();
        check("held_a.no_rejump", 32'(bus.jump_pulse), 0);
        check("held_a.state", 32'(bus.state), 0);
        check("held_a.land_gone", 32'(bus.land_pulse), 0);

        // Short jump: release A after three rise frames.
        set_btn(B_NONE);
        tick();
        set_btn(B_A);
        ticks(4);
        check("short3.pos_y", 32'(bus.pos_y), 367);
        check("short3.state", 32'(bus.state), 1);
        set_btn(B_NONE);
        tick();
        check("release.pos_y", 32'(bus.pos_y), 367);
        check("release.state", 32'(bus.state), 2);
        tick();
        check("release1.pos_y", 32'(bus.pos_y), 368);
        for (int i = 0; i < 60; i++) begin
            if (bus.state == 2'd0) break;
            tick();
        end
        check("short.landed_state", 32'(bus.state), 0);
        check("short.landed_pos_y", 32'(bus.pos_y), 400);

        // Pause freezes motion; Start edge together with A edge gives no jump.
        set_btn(B_START);
        tick();
        check("pause.on", 32'(bus.paused), 1);
        set_btn(B_LEFT | B_A);
        ticks(5);
        check("paused.pos_x", 32'(bus.pos_x), 608);
        check("paused.pos_y", 32'(bus.pos_y), 400);
        check("paused.state", 32'(bus.state), 0);
        check("paused.facing", 32'(bus.facing_left), 0);
        set_btn(B_NONE);
        tick();
        set_btn(B_START);
        tick();
        check("pause.off", 32'(bus.paused), 0);
        set_btn(B_NONE);
        tick();
        set_btn(B_LEFT);
        tick();
        check("resume.pos_x", 32'(bus.pos_x), 606);
        check("resume.facing", 32'(bus.facing_left), 1);
        set_btn(B_START | B_A);
        tick();
        check("start_a.paused", 32'(bus.paused), 1);
        check("start_a.no_jump", 32'(bus.jump_pulse), 0);
        check("start_a.state", 32'(bus.state), 0);
        set_btn(B_NONE);
        tick();
        set_btn(B_START);
        tick();
        check("unpause2", 32'(bus.paused), 0);
        set_btn(B_NONE);
        tick();

        // Crouch blocks walking and jumping.
        set_btn(B_DOWN | B_RIGHT | B_A);
        tick();
        check("crouch.on", 32'(bus.crouch), 1);
        check("crouch.pos_x", 32'(bus.pos_x), 606);
        check("crouch.no_jump", 32'(bus.jump_pulse), 0);
        check("crouch.state", 32'(bus.state), 0);
        set_btn(B_NONE);
        tick();
        check("crouch.off", 32'(bus.crouch), 0);

        // Asynchronous reset in the middle of a rise, with ticks arriving during reset.
        set_btn(B_A);
        jump_cnt = 0;
        tick();
        if (bus.jump_pulse) jump_cnt++;
        ticks(2);
        check("prereset.jump_count", 32'(jump_cnt), 1);
        check("prereset.pos_y", 32'(bus.pos_y), 377);
        check("prereset.state", 32'(bus.state), 1);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        bus.frame_tick = 1'b1;
        repeat (4) @(negedge clk);
        bus.frame_tick = 1'b0;
        check_reset_values("reset_held");
        rst_n = 1'b1;
        tick();
        check("post_reset.jump", 32'(bus.jump_pulse), 1);
        check("post_reset.state", 32'(bus.state), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
